// File: rtl/sc_mem_pkg.sv
// rtl/sc_mem_pkg.sv - shared constants and tag type for the scratch-memory arbiter
package sc_mem_pkg;

  localparam int NUM_REQ  = 3;
  localparam int REQ_HIST = 0;
  localparam int REQ_DIV  = 1;
  localparam int REQ_MAP  = 2;

  localparam int SC_ADDR_W = 16;
  localparam int SC_DATA_W = 128;
  localparam int SC_RD_LAT = 2;

  // Read tag travelling alongside the scratch read latency
  typedef struct packed {
    logic       valid;
    logic [1:0] owner;
  } sc_tag_t;

  // One-hot requester vector for a requester id
  function automatic logic [NUM_REQ-1:0] owner_onehot(input logic [1:0] id);
    logic [NUM_REQ-1:0] one;
    one = {{(NUM_REQ-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

endpackage

// File: rtl/sc_arb_pick.sv
// rtl/sc_arb_pick.sv - combinational winner select; SC_ARB_RR_EN selects round-robin
module sc_arb_pick
  import sc_mem_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig_i,
`ifdef SC_ARB_RR_EN
  input  logic [1:0]         ptr_i,
`endif
  output logic               win_valid_o,
  output logic [1:0]         win_id_o
);

`ifdef SC_ARB_RR_EN
  logic [1:0] cand;

  // Candidate id k steps above the pointer, wrapping over the requesters
  function automatic logic [1:0] rr_index(input logic [1:0] p, input int k);
    int unsigned s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return 2'(s);
  endfunction

  // Walk from farthest to nearest so the requester closest above the pointer wins
  always_comb begin
    win_valid_o = 1'b0;
    win_id_o    = 2'd0;
    cand        = 2'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = rr_index(ptr_i, k);
      if (elig_i[cand]) begin
        win_valid_o = 1'b1;
        win_id_o    = cand;
      end
    end
  end
`else
  // Fixed priority: higher id overrides, so map beats div beats hist
  always_comb begin
    win_valid_o = 1'b0;
    win_id_o    = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (elig_i[k]) begin
        win_valid_o = 1'b1;
        win_id_o    = 2'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/sc_mem_arbiter.sv
// rtl/sc_mem_arbiter.sv - scratch-memory arbiter for hist/div/map; SC_ARB_RR_EN enables round-robin
module sc_mem_arbiter
  import sc_mem_pkg::*;
#(
  parameter int ADDR_W = SC_ADDR_W,
  parameter int DATA_W = SC_DATA_W,
  parameter int RD_LAT = SC_RD_LAT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr1,
  input  logic [NUM_REQ*ADDR_W-1:0] addr2,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata1,
  output logic [DATA_W-1:0]         rdata2,
  output logic [ADDR_W-1:0]         sc_mem_rd_addr1,
  output logic [ADDR_W-1:0]         sc_mem_rd_addr2,
  input  logic [DATA_W-1:0]         sc_mem_rd_data1,
  input  logic [DATA_W-1:0]         sc_mem_rd_data2,
  output logic [ADDR_W-1:0]         sc_mem_wt_addr,
  output logic [DATA_W-1:0]         sc_mem_wt_data,
  output logic                      sc_mem_wt_en,
  output logic                      arb_busy
);

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [ADDR_W-1:0]  rd_addr1_q, rd_addr1_d;
  logic [ADDR_W-1:0]  rd_addr2_q, rd_addr2_d;
  logic [ADDR_W-1:0]  wt_addr_q, wt_addr_d;
  logic [DATA_W-1:0]  wt_data_q, wt_data_d;
  logic               wt_en_q, wt_en_d;
  logic               busy_q, busy_d;
  logic               lock_held_q, lock_held_d;
  logic [1:0]         lock_owner_q, lock_owner_d;
  sc_tag_t            tag_q [RD_LAT];
  sc_tag_t            tag_d [RD_LAT];

  logic [ADDR_W-1:0]  a1_arr [NUM_REQ];
  logic [ADDR_W-1:0]  a2_arr [NUM_REQ];
  logic [DATA_W-1:0]  wd_arr [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic               win_valid;
  logic [1:0]         win_id;

`ifdef SC_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;
`endif

  // Split the packed per-requester buses into indexable arrays
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a1_arr[i] = addr1[i*ADDR_W +: ADDR_W];
      a2_arr[i] = addr2[i*ADDR_W +: ADDR_W];
      wd_arr[i] = wdata[i*DATA_W +: DATA_W];
    end
  end

  // Eligibility: last cycle's grantee is masked (its req is still up while it sees gnt); a lock admits only its owner
  always_comb begin
    elig = req & ~gnt_q;
    if (lock_held_q) elig = elig & owner_onehot(lock_owner_q);
  end

  sc_arb_pick u_pick (
    .elig_i      (elig),
`ifdef SC_ARB_RR_EN
    .ptr_i       (ptr_q),
`endif
    .win_valid_o (win_valid),
    .win_id_o    (win_id)
  );

  // Next state: issue the winner's access, update lock, shift the read-tag pipe
  always_comb begin
    gnt_d        = '0;
    wt_en_d      = 1'b0;
    wt_addr_d    = wt_addr_q;
    wt_data_d    = wt_data_q;
    rd_addr1_d   = rd_addr1_q;
    rd_addr2_d   = rd_addr2_q;
    lock_held_d  = lock_held_q;
    lock_owner_d = lock_owner_q;
    tag_d[0]     = '0;
    for (int k = 1; k < RD_LAT; k++) tag_d[k] = tag_q[k-1];

    if (win_valid) begin
      gnt_d        = owner_onehot(win_id);
      // Only the owner can win while locked, so its lock bit alone decides hold/release
      lock_held_d  = lock[win_id];
      lock_owner_d = win_id;
      if (we[win_id]) begin
        wt_en_d   = 1'b1;
        wt_addr_d = a1_arr[win_id];
        wt_data_d = wd_arr[win_id];
      end else begin
        rd_addr1_d     = a1_arr[win_id];
        rd_addr2_d     = a2_arr[win_id];
        tag_d[0].valid = 1'b1;
        tag_d[0].owner = win_id;
      end
    end

    rvalid_d = '0;
    if (tag_q[RD_LAT-1].valid) rvalid_d = owner_onehot(tag_q[RD_LAT-1].owner);

    busy_d = lock_held_d;
    for (int k = 0; k < RD_LAT; k++) busy_d = busy_d | tag_d[k].valid;
  end

`ifdef SC_ARB_RR_EN
  // Pointer moves to one past the last winner
  always_comb begin
    ptr_d = ptr_q;
    if (win_valid) ptr_d = (win_id == 2'(NUM_REQ - 1)) ? 2'd0 : win_id + 2'd1;
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= 2'd0;
    else          ptr_q <= ptr_d;
  end
`endif

  // Output, lock and tag-pipe registers; reset drops any in-flight read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q        <= '0;
      rvalid_q     <= '0;
      rd_addr1_q   <= '0;
      rd_addr2_q   <= '0;
      wt_addr_q    <= '0;
      wt_data_q    <= '0;
      wt_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      lock_held_q  <= 1'b0;
      lock_owner_q <= 2'd0;
      for (int k = 0; k < RD_LAT; k++) tag_q[k] <= '0;
    end else begin
      gnt_q        <= gnt_d;
      rvalid_q     <= rvalid_d;
      rd_addr1_q   <= rd_addr1_d;
      rd_addr2_q   <= rd_addr2_d;
      wt_addr_q    <= wt_addr_d;
      wt_data_q    <= wt_data_d;
      wt_en_q      <= wt_en_d;
      busy_q       <= busy_d;
      lock_held_q  <= lock_held_d;
      lock_owner_q <= lock_owner_d;
      for (int k = 0; k < RD_LAT; k++) tag_q[k] <= tag_d[k];
    end
  end

  assign gnt             = gnt_q;
  assign rvalid          = rvalid_q;
  assign rdata1          = sc_mem_rd_data1;
  assign rdata2          = sc_mem_rd_data2;
  assign sc_mem_rd_addr1 = rd_addr1_q;
  assign sc_mem_rd_addr2 = rd_addr2_q;
  assign sc_mem_wt_addr  = wt_addr_q;
  assign sc_mem_wt_data  = wt_data_q;
  assign sc_mem_wt_en    = wt_en_q;
  assign arb_busy        = busy_q;

endmodule
